// File: rtl/usart_receive.sv
// ---------------------------------------------------------------------------
// usart_receive
//   8N1 serial receiver with a framed-packet parser on top.
//   Frame format: 0xA5, N (1..MAX_LEN), N payload bytes, checksum, where the
//   checksum is (N + sum of payload) mod 256.
//
// Parameters
//   CLK_FREQ     system clock frequency in Hz
//   BAUD         serial bit rate
//   MAX_LEN      largest accepted payload length in bytes
//   TIMEOUT_BITS idle bit-times allowed between bytes inside a frame
//
// Ports
//   CLOCK_50M       in   system clock, rising edge
//   RST_n           in   asynchronous active-low reset
//   Rx_Pin          in   asynchronous serial line, idle high, LSB first
//   Data[7:0]       out  current payload byte, held until the next Data_Valid
//   Data_Valid      out  one-cycle strobe per payload byte
//   Frame_Start_Sig out  one-cycle strobe when header and length are accepted
//   Frame_Done_Sig  out  one-cycle strobe when the checksum matches
//   Frame_Err       out  one-cycle strobe on a frame, line or timeout error
// ---------------------------------------------------------------------------
module usart_receive #(
    parameter int unsigned CLK_FREQ     = 50_000_000,
    parameter int unsigned BAUD         = 115200,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_BITS = 100
) (
    input  logic       CLOCK_50M,
    input  logic       RST_n,
    input  logic       Rx_Pin,
    output logic [7:0] Data,
    output logic       Data_Valid,
    output logic       Frame_Start_Sig,
    output logic       Frame_Done_Sig,
    output logic       Frame_Err
);

    localparam int unsigned BIT_CNT  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_CNT = BIT_CNT / 2;
    localparam int unsigned TMO_CNT  = TIMEOUT_BITS * BIT_CNT;
    localparam int unsigned CNT_W    = $clog2(BIT_CNT + 1);
    localparam int unsigned TMO_W    = $clog2(TMO_CNT + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CNT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TMO_CNT);
    localparam logic [7:0]       LEN_MAX   = 8'(MAX_LEN);
    localparam logic [7:0]       HEADER    = 8'hA5;

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
    typedef enum logic [1:0] {F_HUNT, F_LEN, F_PAYLOAD, F_CSUM} frame_state_t;

    // -----------------------------------------------------------------------
    // Input synchroniser; rx_prev is the previous synchronised value used for
    // start-edge detection.
    // -----------------------------------------------------------------------
    logic rx_meta;
    logic rx;
    logic rx_prev;

    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= Rx_Pin;
            rx      <= rx_meta;
            rx_prev <= rx;
        end
    end

    // -----------------------------------------------------------------------
    // Bit-level FSM
    // -----------------------------------------------------------------------
    bit_state_t       bit_state;
    logic [CNT_W-1:0] bit_timer;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            bit_state <= B_IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            case (bit_state)
                B_IDLE: begin
                    if (rx_prev && !rx) begin
                        bit_state <= B_START;
                        bit_timer <= '0;
                    end
                end
                B_START: begin
                    // Mid-start-bit check: a line already back high was a glitch.
                    if (bit_timer == HALF_LAST) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        bit_state <= rx ? B_IDLE : B_DATA;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                B_DATA: begin
                    if (bit_timer == BIT_LAST) begin
                        bit_timer <= '0;
                        shift_reg <= {rx, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            bit_state <= B_STOP;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                B_STOP: begin
                    if (bit_timer == BIT_LAST) begin
                        bit_timer <= '0;
                        bit_state <= B_IDLE;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                default: bit_state <= B_IDLE;
            endcase
        end
    end

    // Stop-bit sample cycle results; shift_reg holds the byte during it.
    logic byte_ok;
    logic line_err;

    always_comb begin
        byte_ok  = 1'b0;
        line_err = 1'b0;
        if (bit_state == B_STOP && bit_timer == BIT_LAST) begin
            byte_ok  = rx;
            line_err = !rx;
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM with registered strobes
    // -----------------------------------------------------------------------
    frame_state_t     frame_state;
    logic [7:0]       frame_len;
    logic [7:0]       byte_cnt;
    logic [7:0]       csum;
    logic [TMO_W-1:0] idle_timer;
    logic             timed_out;

    assign timed_out = !byte_ok && (idle_timer == TMO_LAST);

    always_ff @(posedge CLOCK_50M or negedge RST_n) begin
        if (!RST_n) begin
            frame_state     <= F_HUNT;
            frame_len       <= '0;
            byte_cnt        <= '0;
            csum            <= '0;
            idle_timer      <= '0;
            Data            <= '0;
            Data_Valid      <= 1'b0;
            Frame_Start_Sig <= 1'b0;
            Frame_Done_Sig  <= 1'b0;
            Frame_Err       <= 1'b0;
        end else begin
            Data_Valid      <= 1'b0;
            Frame_Start_Sig <= 1'b0;
            Frame_Done_Sig  <= 1'b0;
            Frame_Err       <= 1'b0;

            // Inter-byte timer only runs inside a frame; saturates at its limit.
            if (frame_state == F_HUNT || byte_ok) begin
                idle_timer <= '0;
            end else if (idle_timer != TMO_MAX) begin
                idle_timer <= idle_timer + 1'b1;
            end

            if (frame_state != F_HUNT && (line_err || timed_out)) begin
                Frame_Err   <= 1'b1;
                frame_state <= F_HUNT;
            end else if (byte_ok) begin
                case (frame_state)
                    F_HUNT: begin
                        if (shift_reg == HEADER) begin
                            frame_state <= F_LEN;
                        end
                    end
                    F_LEN: begin
                        if (shift_reg != 8'd0 && shift_reg <= LEN_MAX) begin
                            frame_len       <= shift_reg;
                            csum            <= shift_reg;
                            byte_cnt        <= '0;
                            Frame_Start_Sig <= 1'b1;
                            frame_state     <= F_PAYLOAD;
                        end else begin
                            Frame_Err   <= 1'b1;
                            frame_state <= F_HUNT;
                        end
                    end
                    F_PAYLOAD: begin
                        Data       <= shift_reg;
                        Data_Valid <= 1'b1;
                        csum       <= csum + shift_reg;
                        byte_cnt   <= byte_cnt + 8'd1;
                        if (byte_cnt + 8'd1 == frame_len) begin
                            frame_state <= F_CSUM;
                        end
                    end
                    F_CSUM: begin
                        if (shift_reg == csum) begin
                            Frame_Done_Sig <= 1'b1;
                        end else begin
                            Frame_Err <= 1'b1;
                        end
                        frame_state <= F_HUNT;
                    end
                    default: frame_state <= F_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usart_receive.sv
// ---------------------------------------------------------------------------
// tb_usart_receive
//   Self-checking bench for usart_receive. Byte streams (plus line-error,
//   timeout, reset and glitch tokens) are driven serially; a frame-level
//   reference model turns the same token stream into the expected list of
//   output strobes, which is compared against the strobes observed.
//   The bit rate is scaled down to 32 clocks per bit to keep runs short.
// ---------------------------------------------------------------------------
module tb_usart_receive;

    localparam int CLK_FREQ     = 3_200_000;
    localparam int BAUD         = 100_000;
    localparam int MAX_LEN      = 16;
    localparam int TIMEOUT_BITS = 100;
    localparam int BIT          = CLK_FREQ / BAUD;
    localparam int GLITCH       = BIT / 6;
    localparam int TMO_IDLE     = (TIMEOUT_BITS + 1) * BIT;

    // Stream tokens other than plain byte values
    localparam int T_LINE   = -1;   // byte 0x0A sent with a stop bit of 0
    localparam int T_TMO    = -2;   // line idles for TIMEOUT_BITS+1 bit-times
    localparam int T_RST    = -3;   // reset pulse
    localparam int T_GLITCH = -4;   // short low pulse on the line

    // Observed/expected event encoding
    localparam int EV_START = 256;
    localparam int EV_DATA  = 512;
    localparam int EV_DONE  = 768;
    localparam int EV_ERR   = 1024;

    logic       CLOCK_50M = 1'b0;
    logic       RST_n     = 1'b0;
    logic       Rx_Pin    = 1'b1;
    logic [7:0] Data;
    logic       Data_Valid;
    logic       Frame_Start_Sig;
    logic       Frame_Done_Sig;
    logic       Frame_Err;

    usart_receive #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .CLOCK_50M      (CLOCK_50M),
        .RST_n          (RST_n),
        .Rx_Pin         (Rx_Pin),
        .Data           (Data),
        .Data_Valid     (Data_Valid),
        .Frame_Start_Sig(Frame_Start_Sig),
        .Frame_Done_Sig (Frame_Done_Sig),
        .Frame_Err      (Frame_Err)
    );

    always #5 CLOCK_50M = ~CLOCK_50M;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int obs_q[$];
    int obs_cyc_q[$];
    int exp_q[$];
    int byte_start_q[$];

    int         overlap_cnt = 0;
    int         hold_viol   = 0;
    logic [7:0] prev_data   = 8'h00;
    logic       prev_rst    = 1'b0;

    always @(posedge CLOCK_50M) cyc <= cyc + 1;

    // Output monitor, sampled on the inactive edge
    always @(negedge CLOCK_50M) begin
        if (Frame_Start_Sig) begin obs_q.push_back(EV_START); obs_cyc_q.push_back(cyc); end
        if (Data_Valid) begin obs_q.push_back(EV_DATA + int'(Data)); obs_cyc_q.push_back(cyc); end
        if (Frame_Done_Sig) begin obs_q.push_back(EV_DONE); obs_cyc_q.push_back(cyc); end
        if (Frame_Err) begin obs_q.push_back(EV_ERR); obs_cyc_q.push_back(cyc); end
        if (Frame_Done_Sig && Frame_Err) overlap_cnt++;
        if (RST_n && prev_rst && !Data_Valid && Data !== prev_data) hold_viol++;
        prev_data = Data;
        prev_rst  = RST_n;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50M);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        byte_start_q.push_back(cyc);
        Rx_Pin = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            Rx_Pin = b[i];
            tick(BIT);
        end
        Rx_Pin = stop_bit;
        tick(BIT);
        Rx_Pin = 1'b1;
    endtask

    task automatic drive_token(input int t);
        logic [7:0] bv;
        case (t)
            T_LINE: begin
                send_byte(8'h0A, 1'b0);
                tick(2 * BIT);
            end
            T_TMO: tick(TMO_IDLE);
            T_RST: begin
                RST_n = 1'b0;
                tick(3);
                RST_n = 1'b1;
                tick(BIT);
            end
            T_GLITCH: begin
                Rx_Pin = 1'b0;
                tick(GLITCH);
                Rx_Pin = 1'b1;
                tick(2 * BIT);
            end
            default: begin
                bv = t[7:0];
                send_byte(bv, 1'b1);
                tick(int'($urandom_range(0, 2)) * BIT);
            end
        endcase
    endtask

    // Frame-level reference: parses the token stream into expected strobes.
    function automatic void model(input int toks[$]);
        int s[$];
        int i, len, sum, t;
        foreach (toks[j]) if (toks[j] != T_GLITCH) s.push_back(toks[j]);
        i = 0;
        while (i < s.size()) begin
            if (s[i] != 'hA5) begin
                i++;
                continue;
            end
            i++;
            if (i >= s.size()) break;
            len = s[i];
            i++;
            if (len < 0) begin
                if (len != T_RST) exp_q.push_back(EV_ERR);
                continue;
            end
            if (len == 0 || len > MAX_LEN) begin
                exp_q.push_back(EV_ERR);
                continue;
            end
            exp_q.push_back(EV_START);
            sum = len;
            for (int k = 0; k <= len && i < s.size(); k++) begin
                t = s[i];
                i++;
                if (t < 0) begin
                    if (t != T_RST) exp_q.push_back(EV_ERR);
                    break;
                end
                if (k < len) begin
                    exp_q.push_back(EV_DATA + t);
                    sum += t;
                end else begin
                    exp_q.push_back((sum % 256 == t) ? EV_DONE : EV_ERR);
                end
            end
        end
    endfunction

    task automatic run_scenario(input string name, input int toks[$]);
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        byte_start_q.delete();
        model(toks);
        foreach (toks[i]) drive_token(toks[i]);
        tick(4 * BIT);
        check_eq({name, "_events"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            check_eq($sformatf("%s_ev%0d", name, k), obs_q[k], exp_q[k]);
    endtask

    initial begin
        int q[$];
        int diff;
        int len, sum, b, kind;

        // Reset state
        RST_n  = 1'b0;
        Rx_Pin = 1'b1;
        tick(3);
        check_eq("rst_data", int'(Data), 0);
        check_eq("rst_valid", int'(Data_Valid), 0);
        check_eq("rst_start", int'(Frame_Start_Sig), 0);
        check_eq("rst_done", int'(Frame_Done_Sig), 0);
        check_eq("rst_err", int'(Frame_Err), 0);
        RST_n = 1'b1;
        tick(2 * BIT);

        // Good frame, plus strobe timing against the length byte
        q = {'hA5, 'h03, 'h11, 'h22, 'h33, 'h69};
        run_scenario("good", q);
        diff = (obs_cyc_q.size() > 0 && byte_start_q.size() > 1) ? obs_cyc_q[0] - byte_start_q[1] : -1;
        check_eq("start_in_stop_bit", int'(diff > 9 * BIT && diff < 10 * BIT), 1);
        check_eq("data_hold", int'(Data), 'h33);

        q = {'hA5, 'h03, 'h11, 'h22, 'h33, 'h68};
        run_scenario("badsum", q);

        q = {T_GLITCH, 'hA5, 'h01, 'h7E, 'h7F};
        run_scenario("glitch", q);

        q = {'hA5, 'h00, 'hA5, 'h11};
        run_scenario("badlen", q);

        q = {'hA5, 'h02, T_LINE, 'hA5, 'h02, 'h0A, 'h0B, 'h17};
        run_scenario("lineerr", q);

        q = {'hA5, 'h02, 'h0A, T_TMO, 'hA5, 'h02, 'h0A, 'h0B, 'h17};
        run_scenario("timeout", q);

        q = {'hA5, 'h02, 'h0A, T_RST, 'h0B, 'h0D, 'hA5, 'h01, 'h55, 'h56};
        run_scenario("midreset", q);

        // Randomised frames: junk, bad lengths, bad checksums, line errors,
        // header bytes inside payloads; a final idle flushes any open frame.
        q.delete();
        for (int f = 0; f < 8; f++) begin
            for (int j = int'($urandom_range(0, 2)); j > 0; j--) begin
                b = int'($urandom_range(0, 255));
                q.push_back(b == 'hA5 ? 'h5A : b);
            end
            q.push_back('hA5);
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                q.push_back($urandom_range(0, 1) ? 0 : int'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                len = int'($urandom_range(1, 4));
                q.push_back(len);
                sum = len;
                for (int k = 0; k < len; k++) begin
                    b = ($urandom_range(0, 5) == 0) ? 'hA5 : int'($urandom_range(0, 255));
                    if (kind == 1 && k == len - 1) q.push_back(T_LINE);
                    else begin
                        q.push_back(b);
                        sum += b;
                    end
                end
                if (kind != 1) q.push_back(kind == 2 ? (sum + 1) % 256 : sum % 256);
            end
        end
        q.push_back(T_TMO);
        run_scenario("rand", q);

        check_eq("done_err_overlap", overlap_cnt, 0);
        check_eq("data_hold_violations", hold_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
